// File: rtl/alu_req_seq.sv
// Request sequencer for a 4-bit ALU. It registers one operation onto the ALU ports and spends one
// EXEC cycle on it. The shaped result then goes into a two-entry in-order response FIFO.
module alu_req_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [3:0] req_x,
    input  logic [3:0] req_y,
    output logic [2:0] alu_select,
    output logic       alu_in_c,
    output logic [3:0] alu_in_x,
    output logic [3:0] alu_in_y,
    input  logic [3:0] alu_out_s,
    input  logic       alu_out_c,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_s,
    output logic [3:0] rsp_flags,
    output logic [7:0] err_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    logic [0:0] state;
    logic [7:0] fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       accept;
    logic       push;
    logic       pop;
    logic [7:0] rsp_entry;

    // Packs {err, c, z, ov, s[3:0]} for one completed operation.
    function automatic logic [7:0] shape_rsp(input logic [2:0] op, input logic [3:0] s,
                                             input logic c, input logic z, input logic ov);
        logic [3:0] res;
        logic [3:0] flg;
        res = s;
        flg = {2'b00, (s == 4'd0), 1'b0};
        case (op)
            OP_ADD, OP_SUB: flg = {1'b0, c, z, ov};
            OP_SLT: begin
                res = {3'b000, s[0]};
                flg = {1'b0, c, (res == 4'd0), ov};
            end
            OP_RSV: begin
                res = 4'd0;
                flg = 4'b1000;
            end
            default: flg = {2'b00, (s == 4'd0), 1'b0};
        endcase
        return {flg, res};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign req_ready = (state == IDLE) && (count < 2'd2);
    assign accept    = req_valid && req_ready;
    assign push      = (state == EXEC);
    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_entry = shape_rsp(alu_select, alu_out_s, alu_out_c, alu_zero, alu_overflow);
    assign rsp_s     = rsp_valid ? fifo_mem[rd_ptr][3:0] : 4'd0;
    assign rsp_flags = rsp_valid ? fifo_mem[rd_ptr][7:4] : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= EXEC;
                EXEC:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ALU port registers only move on an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_select <= 3'd0;
            alu_in_c   <= 1'b0;
            alu_in_x   <= 4'd0;
            alu_in_y   <= 4'd0;
        end else if (accept) begin
            alu_select <= req_op;
            alu_in_c   <= (req_op == OP_SUB) || (req_op == OP_SLT);
            alu_in_x   <= req_x;
            alu_in_y   <= req_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= 8'd0;
            fifo_mem[1] <= 8'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rsp_entry;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (push && (alu_select == OP_RSV)) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_alu_req_seq.sv
// Directed bench for alu_req_seq. The bench plays the ALU with a small behavioural model whose
// unused flags are deliberately noisy, so forced-to-zero flags are really exercised.
module tb_alu_req_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic [3:0] req_x = 4'd0;
    logic [3:0] req_y = 4'd0;
    logic [2:0] alu_select;
    logic       alu_in_c;
    logic [3:0] alu_in_x;
    logic [3:0] alu_in_y;
    logic [3:0] alu_out_s;
    logic       alu_out_c;
    logic       alu_zero;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_s;
    logic [3:0] rsp_flags;
    logic [7:0] err_cnt;
    logic       zero_inv = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_req_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_x(req_x), .req_y(req_y),
        .alu_select(alu_select), .alu_in_c(alu_in_c),
        .alu_in_x(alu_in_x), .alu_in_y(alu_in_y),
        .alu_out_s(alu_out_s), .alu_out_c(alu_out_c),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_s(rsp_s), .rsp_flags(rsp_flags), .err_cnt(err_cnt)
    );

    // Behavioural 4-bit ALU; logic ops and the reserved code emit noisy carry/overflow.
    logic [3:0] m_s;
    logic       m_c;
    logic       m_ov;
    logic [4:0] sum;
    always_comb begin
        m_s  = 4'd0;
        m_c  = 1'b0;
        m_ov = 1'b0;
        sum  = 5'd0;
        case (alu_select)
            3'b000: begin
                sum  = {1'b0, alu_in_x} + {1'b0, alu_in_y};
                m_s  = sum[3:0];
                m_c  = sum[4];
                m_ov = (alu_in_x[3] == alu_in_y[3]) && (sum[3] != alu_in_x[3]);
            end
            3'b001, 3'b110: begin
                sum  = {1'b0, alu_in_x} + {1'b0, ~alu_in_y} + {4'd0, alu_in_c};
                m_s  = sum[3:0];
                m_c  = sum[4];
                m_ov = (alu_in_x[3] != alu_in_y[3]) && (sum[3] != alu_in_x[3]);
                if (alu_select == 3'b110) m_s[0] = ($signed(alu_in_x) < $signed(alu_in_y));
            end
            3'b010: begin m_s = ~alu_in_x;           m_c = 1'b1; m_ov = 1'b1; end
            3'b011: begin m_s = alu_in_x & alu_in_y; m_c = 1'b1; m_ov = 1'b1; end
            3'b100: begin m_s = alu_in_x | alu_in_y; m_c = 1'b1; m_ov = 1'b1; end
            3'b101: begin m_s = alu_in_x ^ alu_in_y; m_c = 1'b1; m_ov = 1'b1; end
            default: begin m_s = 4'hF; m_c = 1'b1; m_ov = 1'b1; end
        endcase
    end
    assign alu_out_s    = m_s;
    assign alu_out_c    = m_c;
    assign alu_overflow = m_ov;
    assign alu_zero     = (m_s == 4'd0) ^ zero_inv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One op with rsp_ready held high: accept, EXEC push, then pop.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] x,
                          input logic [3:0] y, input logic exp_c, input logic [3:0] exp_s,
                          input logic [3:0] exp_f);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op = op; req_x = x; req_y = y;
        chk({tag, "_ready"}, {7'd0, req_ready}, 8'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_sel"}, {5'd0, alu_select}, {5'd0, op});
        chk({tag, "_cin"}, {7'd0, alu_in_c}, {7'd0, exp_c});
        chk({tag, "_vld0"}, {7'd0, rsp_valid}, 8'd0);
        tick();
        chk({tag, "_vld1"}, {7'd0, rsp_valid}, 8'd1);
        chk({tag, "_s"}, {4'd0, rsp_s}, {4'd0, exp_s});
        chk({tag, "_flags"}, {4'd0, rsp_flags}, {4'd0, exp_f});
        tick();
        chk({tag, "_pop"}, {7'd0, rsp_valid}, 8'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_vld", {7'd0, rsp_valid}, 8'd0);
        chk("rst_s", {4'd0, rsp_s}, 8'd0);
        chk("rst_flags", {4'd0, rsp_flags}, 8'd0);
        chk("rst_sel", {5'd0, alu_select}, 8'd0);
        chk("rst_x", {4'd0, alu_in_x}, 8'd0);
        chk("rst_err", err_cnt, 8'd0);
        rst_n = 1'b1;
        chk("rel_ready", {7'd0, req_ready}, 8'd1);

        // Directed operations
        run_op("add", 3'b000, 4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0001);
        zero_inv = 1'b1;
        run_op("xor0", 3'b101, 4'b1010, 4'b1010, 1'b0, 4'b0000, 4'b0010);
        zero_inv = 1'b0;
        run_op("sub", 3'b001, 4'b0011, 4'b0101, 1'b1, 4'b1110, 4'b0000);
        run_op("slt", 3'b110, 4'b1000, 4'b0001, 1'b1, 4'b0001, 4'b0101);
        run_op("not", 3'b010, 4'b0101, 4'b0000, 1'b0, 4'b1010, 4'b0000);
        chk("idle_hold_x", {4'd0, alu_in_x}, 8'h05);
        run_op("rsv", 3'b111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b1000);
        chk("err_one", err_cnt, 8'd1);

        // Backpressure: two queued, third stalls, then order and simultaneous push/pop
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op = 3'b000; req_x = 4'b0001; req_y = 4'b0001;
        tick();
        req_op = 3'b011; req_x = 4'b1100; req_y = 4'b1010;
        chk("bp_exec_ready", {7'd0, req_ready}, 8'd0);
        tick();
        chk("bp_a_s", {4'd0, rsp_s}, 8'h02);
        chk("bp_ready1", {7'd0, req_ready}, 8'd1);
        tick();
        req_op = 3'b100; req_x = 4'b0001; req_y = 4'b0010;
        tick();
        chk("bp_full_ready", {7'd0, req_ready}, 8'd0);
        chk("bp_head_a", {4'd0, rsp_s}, 8'h02);
        tick();
        tick();
        chk("bp_stall_sel", {5'd0, alu_select}, 8'h03);
        chk("bp_stall_x", {4'd0, alu_in_x}, 8'h0C);
        chk("bp_stall_ready", {7'd0, req_ready}, 8'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_head_b", {4'd0, rsp_s}, 8'h08);
        chk("bp_flags_b", {4'd0, rsp_flags}, 8'h00);
        chk("bp_sel_still_b", {5'd0, alu_select}, 8'h03);
        tick();
        req_valid = 1'b0;
        chk("bp_c_sel", {5'd0, alu_select}, 8'h04);
        rsp_ready = 1'b1;
        tick();
        chk("bp_pushpop_vld", {7'd0, rsp_valid}, 8'd1);
        chk("bp_head_c", {4'd0, rsp_s}, 8'h03);
        chk("bp_flags_c", {4'd0, rsp_flags}, 8'h00);
        tick();
        chk("bp_empty", {7'd0, rsp_valid}, 8'd0);
        chk("bp_empty_s", {4'd0, rsp_s}, 8'd0);

        // Reset while in EXEC
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op = 3'b011; req_x = 4'b1100; req_y = 4'b0110;
        tick();
        req_valid = 1'b0;
        chk("rx_sel", {5'd0, alu_select}, 8'h03);
        rst_n = 1'b0;
        #1;
        chk("rx_sel0", {5'd0, alu_select}, 8'd0);
        chk("rx_x0", {4'd0, alu_in_x}, 8'd0);
        chk("rx_y0", {4'd0, alu_in_y}, 8'd0);
        chk("rx_err0", err_cnt, 8'd0);
        tick();
        rst_n = 1'b1;
        chk("rx_ready", {7'd0, req_ready}, 8'd1);
        tick();
        tick();
        chk("rx_novld", {7'd0, rsp_valid}, 8'd0);
        chk("rx_s", {4'd0, rsp_s}, 8'd0);
        chk("rx_flags", {4'd0, rsp_flags}, 8'd0);
        chk("rx_cin", {7'd0, alu_in_c}, 8'd0);

        // Saturation of err_cnt
        for (int i = 0; i < 300; i++) begin
            run_op("rsv_loop", 3'b111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b1000);
            if (i == 254) chk("err_255", err_cnt, 8'd255);
        end
        chk("err_sat", err_cnt, 8'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_req_seq.md
ALU_REQ_SEQ -- requirements
Module: alu_req_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  requester has an operation on req_op/req_x/req_y.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_op  input  3  opcode: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 signed less-than, 111 reserved.
REQ-007 req_x, req_y  input  4 each  operands.
REQ-008 alu_select  output  3  select code driven to the 4-bit ALU.
REQ-009 alu_in_c  output  1  ALU carry/subtract control.
REQ-010 alu_in_x, alu_in_y  output  4 each  ALU operands.
REQ-011 alu_out_s  input  4  ALU result.
REQ-012 alu_out_c, alu_zero, alu_overflow  input  1 each  ALU carry, zero and overflow flags.
REQ-013 rsp_valid  output  1  response FIFO head is valid.
REQ-014 rsp_ready  input  1  consumer takes the head response.
REQ-015 rsp_s  output  4  result of the head response.
REQ-016 rsp_flags  output  4  {err, c, z, ov} of the head response.
REQ-017 err_cnt  output  8  saturating count of reserved-opcode requests.

Function
REQ-018 The FSM SHALL have states IDLE and EXEC.
REQ-019 req_ready SHALL be 1 only in IDLE with fewer than 2 FIFO entries.
REQ-020 On req_valid & req_ready, op/x/y SHALL be registered onto alu_select/alu_in_x/alu_in_y, and the FSM SHALL move to EXEC.
REQ-021 alu_in_c SHALL be 1 for ops 001 and 110, and 0 otherwise.
REQ-022 In EXEC, the block SHALL push one response into the FIFO and return to IDLE at the next edge, so throughput is one op per 2 cycles.
REQ-023 Latency SHALL be fixed: a request accepted at edge E0 gives rsp_valid high after E1 when the FIFO was empty.
REQ-024 ALU port registers SHALL hold their last value while IDLE.
REQ-025 For ops 000 and 001, {c, z, ov} SHALL be {alu_out_c, alu_zero, alu_overflow}, and err SHALL be 0.
REQ-026 For ops 010-101, c and ov SHALL be forced to 0, and z SHALL be computed as (alu_out_s == 0), not taken from alu_zero.
REQ-027 For op 110, rsp_s SHALL be {3'b000, alu_out_s[0]}, c = alu_out_c, ov = alu_overflow, and z = (rsp_s == 0).
REQ-028 For op 111, the block SHALL still pass through EXEC and push rsp_s = 0000 with flags 1000, and err_cnt SHALL increment by 1, saturating at 255.
REQ-029 The response FIFO SHALL hold 2 entries in order, with a pop on rsp_valid & rsp_ready.
REQ-030 On a simultaneous push and pop, occupancy SHALL be unchanged and order preserved.
REQ-031 On a push to 1 entry with no pop, occupancy SHALL reach 2, and req_ready SHALL stay 0 until a pop.
REQ-032 When the FIFO is empty, rsp_s and rsp_flags SHALL be 0.
REQ-033 While req_ready = 0, req_valid SHALL be ignored and no ALU register SHALL change.

Reset
REQ-034 When rst_n = 0, state SHALL be IDLE; FIFO empty; rsp_valid = 0; rsp_s, rsp_flags = 0; alu_select, alu_in_c, alu_in_x, alu_in_y = 0; err_cnt = 0.
REQ-035 Reset asserted in EXEC SHALL drop the in-flight op, and no response SHALL appear after release.
REQ-036 After rst_n deasserts, req_ready SHALL be 1 at the first clock.

Verification
REQ-037 Add: op 000, x = 0111, y = 0001, rsp_ready = 1 -> after 2 edges rsp_s = 1000 and rsp_flags = {0, alu_out_c, 0, 1}.
REQ-038 Xor zero: op 101, x = 1010, y = 1010 -> rsp_s = 0000 and flags 0010, regardless of alu_zero.
REQ-039 Backpressure: rsp_ready = 0, three back-to-back ops -> first two queued, req_ready = 0, third stalls until one pop, responses in order.
REQ-040 Reserved: op 111 x = 1111 y = 1111 -> rsp_s = 0000, flags 1000, err_cnt 0 -> 1; 300 such ops -> err_cnt = 255.
REQ-041 Sub/compare: op 001, x = 0011, y = 0101 -> alu_in_c = 1, rsp_s = 1110, ov = 0; op 110, x = 1000, y = 0001 -> alu_in_c = 1, rsp_s = 0001.
REQ-042 Reset in EXEC after accepting op 011 -> rsp_valid stays 0 after release, and all outputs are at reset values.
